// File: rtl/multi_sync_filt_if.sv
// Level-signal bundle for multi_sync_filt: asynchronous inputs in,
// synchronized levels, edge strobes and the any-change flag out.
interface multi_sync_filt_if #(
    parameter int BUS_WIDTH = 4
);
    logic [BUS_WIDTH-1:0] ASYNC;
    logic [BUS_WIDTH-1:0] SYNC;
    logic [BUS_WIDTH-1:0] PULSE;
    logic                 CHANGED;

    // There is no valid/ready handshake: ASYNC is a free-running level per
    // bit, and SYNC/PULSE/CHANGED are updated every CLK rising edge.
    modport master (
        output ASYNC,
        input  SYNC,
        input  PULSE,
        input  CHANGED
    );

    modport slave (
        input  ASYNC,
        output SYNC,
        output PULSE,
        output CHANGED
    );
endinterface

// File: rtl/multi_sync_filt.sv
// Per-bit multi-flop synchronizer with optional debounce filter and
// edge-strobe / any-change decode taken purely from flop outputs.
module multi_sync_filt #(
    parameter int                   BUS_WIDTH  = 4,
    parameter int                   NUM_STAGES = 2,
    parameter int                   FILTER_LEN = 0,
    parameter int                   EDGE_MODE  = 0,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                CLK,
    input  logic                RST,
    multi_sync_filt_if.slave    bus
);

    localparam logic [7:0] FLEN = 8'(FILTER_LEN);

    logic [BUS_WIDTH-1:0] chain_q [NUM_STAGES];
    logic [BUS_WIDTH-1:0] chain_d [NUM_STAGES];
    logic [BUS_WIDTH-1:0] raw;
    logic [BUS_WIDTH-1:0] sync_w;
    logic [BUS_WIDTH-1:0] sync_d_q;
    logic [BUS_WIDTH-1:0] sync_d_d;
    logic [BUS_WIDTH-1:0] chg;
    logic [BUS_WIDTH-1:0] pulse_w;

    // Each bit is an unrelated signal; the vector form is only packaging.
    always_comb begin
        chain_d[0] = bus.ASYNC;
        for (int i = 1; i < NUM_STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                chain_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                chain_q[i] <= chain_d[i];
            end
        end
    end

    assign raw = chain_q[NUM_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign sync_w = raw;
        end else begin : g_filter
            logic [BUS_WIDTH-1:0] cand_q;
            logic [BUS_WIDTH-1:0] cand_d;
            logic [BUS_WIDTH-1:0] filt_q;
            logic [BUS_WIDTH-1:0] filt_d;
            logic [7:0]           cnt_q [BUS_WIDTH];
            logic [7:0]           cnt_d [BUS_WIDTH];

            // A new raw level restarts qualification at 1; once the count
            // reaches FILTER_LEN it saturates and the candidate is committed.
            always_comb begin
                cand_d = cand_q;
                filt_d = filt_q;
                cnt_d  = cnt_q;
                for (int i = 0; i < BUS_WIDTH; i++) begin
                    if (raw[i] != cand_q[i]) begin
                        cand_d[i] = raw[i];
                        cnt_d[i]  = 8'd1;
                    end else if (cnt_q[i] < FLEN) begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end else if (cand_q[i] != filt_q[i]) begin
                        filt_d[i] = cand_q[i];
                    end
                end
            end

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    cand_q <= RST_VAL;
                    filt_q <= RST_VAL;
                    for (int i = 0; i < BUS_WIDTH; i++) begin
                        cnt_q[i] <= 8'd0;
                    end
                end else begin
                    cand_q <= cand_d;
                    filt_q <= filt_d;
                    for (int i = 0; i < BUS_WIDTH; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign sync_w = filt_q;
        end
    endgenerate

    assign sync_d_d = sync_w;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_d_q <= RST_VAL;
        end else begin
            sync_d_q <= sync_d_d;
        end
    end

    // Both operands are flop outputs, so reset forces chg to zero.
    assign chg = sync_w ^ sync_d_q;

    generate
        if (EDGE_MODE == 0) begin : g_rise
            assign pulse_w = chg & sync_w;
        end else if (EDGE_MODE == 1) begin : g_fall
            assign pulse_w = chg & ~sync_w;
        end else begin : g_both
            assign pulse_w = chg;
        end
    endgenerate

    assign bus.SYNC    = sync_w;
    assign bus.PULSE   = pulse_w;
    assign bus.CHANGED = |chg;

endmodule

// File: tb/tb_multi_sync_filt.sv
// Directed checks of multi_sync_filt across several parameter sets,
// each instance with its own interface and reset.
module tb_multi_sync_filt;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    logic rst_d;
    logic rst_e;

    int n_tests;
    int n_fail;

    multi_sync_filt_if #(.BUS_WIDTH(4)) if_a ();
    multi_sync_filt_if #(.BUS_WIDTH(4)) if_b ();
    multi_sync_filt_if #(.BUS_WIDTH(4)) if_c ();
    multi_sync_filt_if #(.BUS_WIDTH(4)) if_d ();
    multi_sync_filt_if #(.BUS_WIDTH(4)) if_e ();

    multi_sync_filt u_a (.CLK(clk), .RST(rst_a), .bus(if_a.slave));

    multi_sync_filt #(.NUM_STAGES(3), .EDGE_MODE(1)) u_b (
        .CLK(clk), .RST(rst_b), .bus(if_b.slave));

    multi_sync_filt #(.FILTER_LEN(3), .EDGE_MODE(0)) u_c (
        .CLK(clk), .RST(rst_c), .bus(if_c.slave));

    multi_sync_filt #(.FILTER_LEN(3), .EDGE_MODE(2)) u_d (
        .CLK(clk), .RST(rst_d), .bus(if_d.slave));

    multi_sync_filt #(.RST_VAL(4'hF)) u_e (
        .CLK(clk), .RST(rst_e), .bus(if_e.slave));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0; rst_e = 1'b0;
        if_a.ASYNC = 4'h0;
        if_b.ASYNC = 4'hF;
        if_c.ASYNC = 4'h0;
        if_d.ASYNC = 4'h0;
        if_e.ASYNC = 4'hF;

        tick(2);
        check("a_rst_sync",    32'(if_a.SYNC),    32'h0);
        check("a_rst_pulse",   32'(if_a.PULSE),   32'h0);
        check("a_rst_changed", 32'(if_a.CHANGED), 32'h0);
        check("b_rst_sync",    32'(if_b.SYNC),    32'h0);
        check("e_rst_sync",    32'(if_e.SYNC),    32'hF);
        check("e_rst_pulse",   32'(if_e.PULSE),   32'h0);
        check("e_rst_changed", 32'(if_e.CHANGED), 32'h0);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;

        // RST_VAL=F with ASYNC=F across release: nothing may move
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("e_hold_sync",    32'(if_e.SYNC),    32'hF);
            check("e_hold_pulse",   32'(if_e.PULSE),   32'h0);
            check("e_hold_changed", 32'(if_e.CHANGED), 32'h0);
        end

        // defaults: 0 -> A, two-edge latency, one-cycle rising strobe
        if_a.ASYNC = 4'hA;
        tick(1);
        check("a_lat1_sync",    32'(if_a.SYNC),    32'h0);
        check("a_lat1_changed", 32'(if_a.CHANGED), 32'h0);
        tick(1);
        check("a_A_sync",    32'(if_a.SYNC),    32'hA);
        check("a_A_pulse",   32'(if_a.PULSE),   32'hA);
        check("a_A_changed", 32'(if_a.CHANGED), 32'h1);
        tick(1);
        check("a_A_pulse_end",   32'(if_a.PULSE),   32'h0);
        check("a_A_changed_end", 32'(if_a.CHANGED), 32'h0);
        // A -> 5: bits 0,2 rise, bits 1,3 fall
        if_a.ASYNC = 4'h5;
        tick(2);
        check("a_5_sync",    32'(if_a.SYNC),    32'h5);
        check("a_5_pulse",   32'(if_a.PULSE),   32'h5);
        check("a_5_changed", 32'(if_a.CHANGED), 32'h1);
        // 5 -> 0: falling only, CHANGED still flags it
        if_a.ASYNC = 4'h0;
        tick(2);
        check("a_0_pulse",   32'(if_a.PULSE),   32'h0);
        check("a_0_changed", 32'(if_a.CHANGED), 32'h1);

        // NUM_STAGES=3, falling edges: F -> 3
        check("b_pre_sync", 32'(if_b.SYNC), 32'hF);
        if_b.ASYNC = 4'h3;
        tick(2);
        check("b_lat2_sync", 32'(if_b.SYNC), 32'hF);
        tick(1);
        check("b_3_sync",  32'(if_b.SYNC),  32'h3);
        check("b_3_pulse", 32'(if_b.PULSE), 32'hC);
        tick(1);
        check("b_3_pulse_end", 32'(if_b.PULSE), 32'h0);
        if_b.ASYNC = 4'hF;
        tick(3);
        check("b_F_sync",    32'(if_b.SYNC),    32'hF);
        check("b_F_pulse",   32'(if_b.PULSE),   32'h0);
        check("b_F_changed", 32'(if_b.CHANGED), 32'h1);

        // FILTER_LEN=3: glitch of exactly 3 sampled edges is rejected
        if_c.ASYNC = 4'h1;
        tick(3);
        if_c.ASYNC = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("c_glitch_sync",  32'(if_c.SYNC),  32'h0);
            check("c_glitch_pulse", 32'(if_c.PULSE), 32'h0);
        end
        // held high: visible after edge 2+3+1 = 6
        if_c.ASYNC = 4'h1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check("c_qual_sync", 32'(if_c.SYNC), 32'h0);
        end
        tick(1);
        check("c_held_sync",  32'(if_c.SYNC),  32'h1);
        check("c_held_pulse", 32'(if_c.PULSE), 32'h1);
        tick(1);
        check("c_held_pulse_end", 32'(if_c.PULSE), 32'h0);
        check("c_held_sync2",     32'(if_c.SYNC),  32'h1);

        // FILTER_LEN=3, both edges: qualify high first
        if_d.ASYNC = 4'h1;
        tick(6);
        check("d_up_sync",  32'(if_d.SYNC),  32'h1);
        check("d_up_pulse", 32'(if_d.PULSE), 32'h1);
        tick(1);
        // low candidate reaches cnt=2, then reset arrives mid-cycle
        if_d.ASYNC = 4'h0;
        tick(4);
        check("d_pending_sync", 32'(if_d.SYNC), 32'h1);
        if_d.ASYNC = 4'h1;
        #2;
        rst_d = 1'b0;
        #1;
        check("d_rst_sync",    32'(if_d.SYNC),    32'h0);
        check("d_rst_pulse",   32'(if_d.PULSE),   32'h0);
        check("d_rst_changed", 32'(if_d.CHANGED), 32'h0);
        tick(1);
        rst_d = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check("d_post_sync",  32'(if_d.SYNC),  32'h0);
            check("d_post_pulse", 32'(if_d.PULSE), 32'h0);
        end
        tick(1);
        check("d_requal_sync",  32'(if_d.SYNC),  32'h1);
        check("d_requal_pulse", 32'(if_d.PULSE), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
